// File: rtl/vcu_insn_dispatcher.sv
// Hardware instruction issuer for the vCU: fetches a batch of instructions from RAM,
// issues each with a one-cycle work_en, and waits for the vcu_done falling edge under a watchdog.
module vcu_insn_dispatcher #(
  parameter int INSN_WIDTH         = 128,
  parameter int INSN_ADDRESS_WIDTH = 10,
  parameter int CNT_WIDTH          = 11,
  parameter int TIMEOUT_CYCLES     = 65535
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [INSN_ADDRESS_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]          insn_num,
  output logic [INSN_ADDRESS_WIDTH-1:0] r_addr_insn,
  output logic                          r_en_insn,
  input  logic [INSN_WIDTH-1:0]         r_data_insn,
  output logic [INSN_WIDTH-1:0]         insn,
  output logic                          work_en,
  input  logic                          vcu_done,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [CNT_WIDTH-1:0]          issued_cnt
);

  localparam int WD_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_FIN
  } state_t;

  state_t                        state, state_nxt;
  logic [INSN_ADDRESS_WIDTH-1:0] addr;
  logic [CNT_WIDTH-1:0]          num;
  logic [WD_WIDTH-1:0]           wd_cnt;
  logic                          done_d;
  logic                          done_seen_arm;
  logic                          completion;
  logic                          timeout_hit;
  logic                          last_insn;

  // A falling edge only counts once a full WAIT cycle has passed since the issue strobe.
  assign completion  = (state == S_WAIT) && done_seen_arm && done_d && !vcu_done;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == S_WAIT) &&
                       (wd_cnt == WD_WIDTH'(TIMEOUT_CYCLES));
  assign last_insn   = (issued_cnt + CNT_WIDTH'(1)) == num;

  assign r_en_insn   = (state == S_FETCH);
  assign r_addr_insn = r_en_insn ? addr : '0;
  assign work_en     = (state == S_ISSUE);
  assign done        = (state == S_FIN);
  assign busy        = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next state gets a default before the case so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = (insn_num == '0) ? S_FIN : S_FETCH;
      S_FETCH: state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (completion)       state_nxt = last_insn ? S_FIN : S_FETCH;
        else if (timeout_hit) state_nxt = S_FIN;
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr          <= '0;
      num           <= '0;
      insn          <= '0;
      issued_cnt    <= '0;
      err           <= 1'b0;
      wd_cnt        <= '0;
      done_d        <= 1'b0;
      done_seen_arm <= 1'b0;
    end else begin
      done_d <= vcu_done;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            addr       <= base_addr;
            num        <= insn_num;
            issued_cnt <= '0;
            err        <= 1'b0;
          end
        end
        S_LOAD: begin
          insn <= r_data_insn;
          addr <= addr + INSN_ADDRESS_WIDTH'(1);
        end
        S_ISSUE: begin
          wd_cnt        <= '0;
          done_seen_arm <= 1'b0;
        end
        S_WAIT: begin
          done_seen_arm <= 1'b1;
          wd_cnt        <= wd_cnt + WD_WIDTH'(1);
          if (completion)       issued_cnt <= issued_cnt + CNT_WIDTH'(1);
          else if (timeout_hit) err        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vcu_insn_dispatcher.sv
// Scoreboard bench for vcu_insn_dispatcher: directed batches push expected RAM reads,
// issues and done pulses (with cycle stamps); a negedge monitor pops and compares.
module tb_vcu_insn_dispatcher;

  localparam int IW  = 128;
  localparam int AW  = 10;
  localparam int CW  = 11;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] insn_num;
  logic [AW-1:0] r_addr_insn;
  logic          r_en_insn;
  logic [IW-1:0] r_data_insn;
  logic [IW-1:0] insn;
  logic          work_en;
  logic          vcu_done;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] issued_cnt;

  vcu_insn_dispatcher #(
    .INSN_WIDTH        (IW),
    .INSN_ADDRESS_WIDTH(AW),
    .CNT_WIDTH         (CW),
    .TIMEOUT_CYCLES    (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .insn_num   (insn_num),
    .r_addr_insn(r_addr_insn),
    .r_en_insn  (r_en_insn),
    .r_data_insn(r_data_insn),
    .insn       (insn),
    .work_en    (work_en),
    .vcu_done   (vcu_done),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .issued_cnt (issued_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Instruction RAM with one-cycle read latency.
  logic [IW-1:0] mem [1024];
  always @(posedge clk) if (r_en_insn) r_data_insn <= mem[r_addr_insn];

  function automatic logic [IW-1:0] pat(input int i);
    return {32'hA5A5_0000 + 32'(i), 32'h0BAD_F00D ^ 32'(i * 7), 64'h1234_5678_9ABC_DEF0 + 64'(i)};
  endfunction

  // vcu model: raises vcu_done during the issue cycle, drops it model_lat cycles later.
  logic auto_mode = 1'b1;
  logic model_done = 1'b0;
  logic man_done = 1'b0;
  int   model_lat = 6;
  int   rem = 0;
  assign vcu_done = auto_mode ? model_done : man_done;

  always begin
    @(posedge clk);
    #1;
    if (work_en) begin
      model_done = 1'b1;
      rem        = model_lat;
    end else if (rem > 0) begin
      rem = rem - 1;
      if (rem == 0) model_done = 1'b0;
    end
  end

  typedef struct { int cyc; logic [AW-1:0] addr; } rd_t;
  typedef struct { int cyc; logic [IW-1:0] data; } iss_t;
  typedef struct { int cyc; logic err; int cnt; } fin_t;

  rd_t  rd_q [$];
  iss_t iss_q[$];
  fin_t fin_q[$];

  rd_t  re;
  iss_t ie;
  fin_t fe;

  // Monitor: every DUT response must match the head of its expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (r_en_insn) begin
        check("rd_expected", rd_q.size() != 0, 1'b1);
        check("rd_no_overlap", work_en, 1'b0);
        if (rd_q.size() != 0) begin
          re = rd_q.pop_front();
          check("rd_cycle", cyc, re.cyc);
          check("rd_addr", r_addr_insn, re.addr);
        end
      end
      if (work_en) begin
        check("issue_expected", iss_q.size() != 0, 1'b1);
        if (iss_q.size() != 0) begin
          ie = iss_q.pop_front();
          check("issue_cycle", cyc, ie.cyc);
          check("issue_insn", insn, ie.data);
        end
      end
      if (done) begin
        check("done_expected", fin_q.size() != 0, 1'b1);
        if (fin_q.size() != 0) begin
          fe = fin_q.pop_front();
          check("done_cycle", cyc, fe.cyc);
          check("done_err", err, fe.err);
          check("done_issued_cnt", issued_cnt, fe.cnt);
        end
      end
    end
  end

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    check("done_within_budget", done, 1'b1);
  endtask

  // Runs a batch against the automatic vcu model. Start is accepted at the edge that makes
  // cyc == s: reads at t-2, issues at t, each next issue lat+3 cycles later, done lat+1 after last.
  task automatic run_auto(input logic [AW-1:0] base, input int num, input int lat);
    int s, t;
    logic [AW-1:0] a;
    auto_mode = 1'b1;
    model_lat = lat;
    @(negedge clk);
    s = cyc + 1;
    t = s + 2;
    a = base;
    for (int k = 0; k < num; k++) begin
      rd_q.push_back(rd_t'{t - 2, a});
      iss_q.push_back(iss_t'{t, mem[a]});
      a = a + AW'(1);
      if (k < num - 1) t = t + lat + 3;
    end
    fin_q.push_back(fin_t'{(num == 0) ? s : t + lat + 1, 1'b0, num});
    start     = 1'b1;
    base_addr = base;
    insn_num  = CW'(num);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    wait_done(num * (lat + 3) + 40);
    @(negedge clk);
    check("idle_after_done", busy, 1'b0);
    check("final_issued_cnt", issued_cnt, CW'(num));
    check("final_err", err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit reached at cycle %0d", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    int s;
    for (int i = 0; i < 1024; i++) mem[i] = pat(i);
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    insn_num  = '0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_work_en", work_en, 1'b0);
    check("rst_r_en", r_en_insn, 1'b0);
    check("rst_insn", insn, '0);
    check("rst_err", err, 1'b0);
    check("rst_issued_cnt", issued_cnt, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Three-instruction batch, work_en spacing 9 cycles.
    run_auto(10'd0, 3, 6);
    // Empty batch: done one cycle after start, busy for exactly one cycle.
    run_auto(10'd0, 0, 6);
    // Address wrap 1022, 1023, 0, 1.
    run_auto(10'd1022, 4, 4);

    // Glitches in ISSUE and first WAIT cycle are ignored; start during WAIT ignored.
    auto_mode = 1'b0;
    man_done  = 1'b0;
    @(negedge clk);
    s = cyc + 1;
    rd_q.push_back(rd_t'{s, 10'd8});
    iss_q.push_back(iss_t'{s + 2, mem[8]});
    rd_q.push_back(rd_t'{s + 9, 10'd9});
    iss_q.push_back(iss_t'{s + 11, mem[9]});
    fin_q.push_back(fin_t'{s + 15, 1'b0, 2});
    start = 1'b1; base_addr = 10'd8; insn_num = 11'd2;
    @(negedge clk);
    start = 1'b0;
    man_done = 1'b1;
    at_cyc(s + 2);  man_done = 1'b0;
    at_cyc(s + 3);  man_done = 1'b1;
    at_cyc(s + 5);  start = 1'b1; base_addr = 10'd100; insn_num = 11'd1;
    at_cyc(s + 6);  start = 1'b0;
    at_cyc(s + 8);  man_done = 1'b0;
    at_cyc(s + 11); man_done = 1'b1;
    at_cyc(s + 12); man_done = 1'b0;
    at_cyc(s + 13); man_done = 1'b1;
    at_cyc(s + 14); man_done = 1'b0;
    wait_done(20);
    @(negedge clk);
    check("glitch_issued_cnt", issued_cnt, 11'd2);

    // Watchdog: vcu_done stuck high, done 17 cycles after WAIT entry.
    man_done = 1'b1;
    @(negedge clk);
    s = cyc + 1;
    rd_q.push_back(rd_t'{s, 10'd5});
    iss_q.push_back(iss_t'{s + 2, mem[5]});
    fin_q.push_back(fin_t'{s + 3 + 17, 1'b1, 0});
    start = 1'b1; base_addr = 10'd5; insn_num = 11'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done(40);
    @(negedge clk);
    check("timeout_err_sticky", err, 1'b1);
    check("timeout_issued_cnt", issued_cnt, 11'd0);
    man_done = 1'b0;
    // Next start clears err (checked in done entry and final_err).
    run_auto(10'd0, 0, 6);

    // Reset mid-WAIT of a five-instruction batch, then a full clean batch.
    auto_mode = 1'b1;
    model_lat = 6;
    @(negedge clk);
    s = cyc + 1;
    rd_q.push_back(rd_t'{s, 10'd0});
    iss_q.push_back(iss_t'{s + 2, mem[0]});
    rd_q.push_back(rd_t'{s + 9, 10'd1});
    iss_q.push_back(iss_t'{s + 11, mem[1]});
    start = 1'b1; base_addr = 10'd0; insn_num = 11'd5;
    @(negedge clk);
    start = 1'b0;
    at_cyc(s + 14);
    check("pre_reset_issued_cnt", issued_cnt, 11'd1);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_insn", insn, '0);
    check("midrst_issued_cnt", issued_cnt, '0);
    check("midrst_done", done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    at_cyc(s + 22);
    run_auto(10'd0, 5, 6);

    repeat (3) @(negedge clk);
    check("rd_queue_drained", rd_q.size(), 0);
    check("issue_queue_drained", iss_q.size(), 0);
    check("done_queue_drained", fin_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vcu_insn_dispatcher.md
# vcu_insn_dispatcher

Hardware instruction issuer for the vCU. It fetches a run of 128-bit instructions from the instruction two-port RAM and presents them one at a time on `insn`, each with a one-cycle `work_en` pulse. After each pulse it waits for the vCU's `vcu_done` falling edge before fetching and issuing the next instruction. It sits between the host/controller and `vcu`, replacing software-driven per-instruction issue, and adds a completion watchdog.

## Interface
- INSN_WIDTH, 128, instruction width
- INSN_ADDRESS_WIDTH, 10, instruction RAM address width
- CNT_WIDTH, 11, width of instruction count / issued counter
- TIMEOUT_CYCLES, 65535, max cycles in WAIT before abort; 0 disables watchdog
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to run a batch; sampled only in IDLE
- base_addr  in  INSN_ADDRESS_WIDTH  first instruction address, latched on accepted start
- insn_num  in  CNT_WIDTH  instructions in batch, latched on accepted start
- r_addr_insn  out  INSN_ADDRESS_WIDTH  instruction RAM read address
- r_en_insn  out  1  instruction RAM read enable
- r_data_insn  in  INSN_WIDTH  RAM read data, valid one cycle after r_en_insn
- insn  out  INSN_WIDTH  instruction to vcu, registered, held stable until next load
- work_en  out  1  one-cycle issue strobe to vcu
- vcu_done  in  1  vcu completion level; completion = falling edge
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at batch end (normal or abort)
- err  out  1  sticky timeout flag, cleared on next accepted start
- issued_cnt  out  CNT_WIDTH  instructions completed in current/last batch

## Operation
- States: IDLE, FETCH, LOAD, ISSUE, WAIT, FIN.
- IDLE: if start, latch base_addr into addr, latch insn_num, clear issued_cnt and err. Go to FIN if insn_num==0, else FETCH. Start outside IDLE is ignored.
- FETCH: r_en_insn=1, r_addr_insn=addr. Go to LOAD.
- LOAD: insn <= r_data_insn; addr <= addr+1, wrapping modulo 2^INSN_ADDRESS_WIDTH. Go to ISSUE.
- ISSUE: work_en=1 for exactly this cycle; clear watchdog counter and done_seen_arm. Go to WAIT.
- WAIT: vcu_done is registered as done_d. Completion = done_d==1 && vcu_done==0, counted only after at least one cycle in WAIT. A vcu_done already low-going in the ISSUE cycle is ignored.
  - On completion: issued_cnt+1; go to FIN if issued_cnt+1==insn_num, else FETCH.
  - Watchdog: when TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES with no completion, set err=1 and go to FIN. Completion and timeout in the same cycle: completion wins.
- FIN: done=1 for one cycle. Go to IDLE.
- r_en_insn and work_en are never high in the same cycle. Only one instruction is ever outstanding.
- Reset value of every output is 0. Reset mid-batch aborts immediately: no done pulse, insn returns to 0.

## Timing
- Start accepted at edge 0 (nonzero insn_num): FETCH cycle 1, LOAD cycle 2, insn valid and ISSUE (work_en=1) cycle 3, WAIT from cycle 4.
- Completion seen at cycle N: next FETCH N+1, next work_en N+3. Inter-issue overhead is 3 cycles after the falling edge.
- Last completion at cycle N: FIN (done=1) at N+1, IDLE and busy=0 at N+2.
- insn_num==0: done=1 one cycle after start, no RAM read, no work_en.
- Timeout: FIN is entered the cycle after the counter equals TIMEOUT_CYCLES. issued_cnt holds the completed count.

## Test plan
- Batch of 3, base_addr=0, RAM[0..2]=A,B,C; vcu model drops vcu_done 5 cycles after work_en -> exactly 3 work_en pulses with insn=A,B,C in order; work_en spacing 3+5+1 cycles; done once; issued_cnt=3; err=0.
- insn_num=0 -> done pulse at start+1; no r_en_insn or work_en; busy high for exactly one cycle.
- base_addr=1022, insn_num=4 -> read addresses 1022,1023,0,1 in order.
- TIMEOUT_CYCLES=16; vcu_done held high -> err=1 and done at 17 cycles after WAIT entry; issued_cnt=0; next start clears err.
- start pulses during WAIT -> ignored; batch count unchanged. vcu_done glitch low-going in the ISSUE cycle -> not counted.
- rst asserted mid-WAIT of a 5-instruction batch -> all outputs 0 asynchronously; no done pulse; new start runs a full batch correctly.
